div_radix2: RTL

DIV_RADIX2 -- requirements
Module: div_radix2

---
 rtl/div_radix2_pkg.sv | 25 ++
 rtl/div_step.sv | 24 ++
 rtl/div_radix2.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM state encoding,
// handshake level names, iteration limit and an operand magnitude helper.
package div_radix2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } div_state_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  // Magnitude of an operand: negate only when signed mode and the value is negative.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic use_sign);
    return (use_sign && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration.
// acc layout: acc[64:32] = partial remainder, acc[31:0] = dividend bits still
// to be consumed (high end) and quotient bits produced so far (low end).
module div_step (
  input  logic [64:0] acc,
  input  logic [31:0] divisor,
  output logic [64:0] acc_next
);

  logic [64:0] shifted;
  logic [32:0] trial;

  // Shift in the next dividend bit, try to subtract; bit 32 of trial is the borrow.
  always_comb begin
    shifted = {acc[63:0], 1'b0};
    trial   = shifted[64:32] - {1'b0, divisor};
    if (trial[32]) begin
      acc_next = shifted;
    end else begin
      acc_next = {trial, shifted[31:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_radix2.sv
// Radix-2 restoring divider, 32/32 -> {remainder, quotient}, signed or unsigned.
// Operands are converted to magnitudes at capture, iterated 32 times, and the
// signs are restored when the result is loaded in END.
// Optional macro DIV_EARLY_TERM_EN: when |dividend| < |divisor| the divide
// skips iteration and goes straight to END with quotient 0.
//
// Handshake: start_i is a request level held until ready_o=1; ready_o stays 1
// (result_o frozen) while start_i stays high, and drops one edge after start_i
// falls. annul_i aborts from any busy state and wins over start_i.
module div_radix2
  import div_radix2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output div_state_t  dbg_state
);

  div_state_t        state;
  div_state_t        state_next;
  logic [64:0]       acc;
  logic [64:0]       acc_next;
  logic [31:0]       divisor_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic [CNT_W-1:0]  count;

  logic [31:0]       mag_a;
  logic [31:0]       mag_b;
  logic              early_term;
  logic [31:0]       quo_fix;
  logic [31:0]       rem_fix;

  logic              capture;
  logic              do_step;
  logic              zero_acc;
  logic              load_res;
  logic              clear_out;

  assign mag_a     = magnitude(opdata1_i, signed_div_i);
  assign mag_b     = magnitude(opdata2_i, signed_div_i);
  assign dbg_state = state;

`ifdef DIV_EARLY_TERM_EN
  assign early_term = (opdata2_i != 32'd0) && (mag_a < mag_b);
`else
  assign early_term = 1'b0;
`endif

  // Sign correction: quotient negative when signs differ, remainder follows dividend.
  assign quo_fix = neg_quo_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_fix = neg_rem_q ? (~acc[63:32] + 32'd1) : acc[63:32];

  div_step u_step (
    .acc      (acc),
    .divisor  (divisor_q),
    .acc_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; annul_i overrides everything outside IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_next = ST_BYZERO;
          end else if (early_term) begin
            state_next = ST_END;
          end else begin
            state_next = ST_ON;
          end
        end
      end
      ST_BYZERO: state_next = annul_i ? ST_IDLE : ST_END;
      ST_ON: begin
        if (annul_i) begin
          state_next = ST_IDLE;
        end else if (count == CNT_W'(DIV_ITER - 1)) begin
          state_next = ST_END;
        end
      end
      ST_END: begin
        if (annul_i) begin
          state_next = ST_IDLE;
        end else if (ready_o == DivResultReady && start_i == DivStop) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output/control decode: which datapath action happens at the next edge.
  always_comb begin
    capture  = 1'b0;
    do_step  = 1'b0;
    zero_acc = 1'b0;
    load_res = 1'b0;
    case (state)
      ST_IDLE:   capture  = (start_i == DivStart) && !annul_i;
      ST_BYZERO: zero_acc = !annul_i;
      ST_ON:     do_step  = !annul_i;
      ST_END:    load_res = !annul_i && (ready_o == DivResultNotReady);
      default:   ;
    endcase
    clear_out = (state != ST_IDLE) && (state_next == ST_IDLE);
  end

  // Datapath: operand capture, iteration, counter and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      count     <= '0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      if (capture) begin
        // Early termination preloads the remainder with |dividend| and quotient 0.
        acc       <= early_term ? {1'b0, mag_a, 32'd0} : {33'd0, mag_a};
        divisor_q <= mag_b;
        neg_quo_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
        neg_rem_q <= signed_div_i & opdata1_i[31];
        count     <= '0;
      end else if (zero_acc) begin
        acc <= '0;
      end else if (do_step) begin
        acc   <= acc_next;
        count <= count + CNT_W'(1);
      end

      if (load_res) begin
        result_o <= {rem_fix, quo_fix};
        ready_o  <= DivResultReady;
      end else if (clear_out) begin
        result_o <= '0;
        ready_o  <= DivResultNotReady;
      end
    end
  end

endmodule
